// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares a single-port data RAM between the pipeline MEM stage and
//            a debug/loader port, with starvation bound and halt handshake.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p_req,
    input  logic          p_we,
    input  logic [AW-1:0] p_addr,
    input  logic [DW-1:0] p_wdata,
    output logic          p_gnt,
    output logic          p_rvalid,
    output logic [DW-1:0] p_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    input  logic          halt_req,
    output logic          halt_ack,
    output logic          pipe_stall,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] C_MAX_WAIT = WW'(MAX_WAIT);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_owner_q, rd_owner_d;
    logic          w_p_gnt, w_d_gnt;

    // Grants are forced low while reset is held so the RAM sees no access.
    always_comb begin
        w_p_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (rst) begin
            if (state_q == S_RUN) begin
                w_p_gnt = p_req & ~(d_req & (wait_q == C_MAX_WAIT));
                w_d_gnt = d_req & ~w_p_gnt;
            end else begin
                w_d_gnt = d_req;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (halt_req) state_d = S_DRAIN;
            S_DRAIN: state_d = S_HALT;
            S_HALT:  if (!halt_req) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        wait_d = '0;
        if (d_req && !w_d_gnt)
            wait_d = (wait_q == C_MAX_WAIT) ? wait_q : wait_q + 1'b1;
    end

    always_comb begin
        m_en    = w_p_gnt | w_d_gnt;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (w_p_gnt) begin
            m_we    = p_we;
            m_addr  = p_addr;
            m_wdata = p_wdata;
        end else if (w_d_gnt) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    // rd_owner_q: 1 = debug issued the read, 0 = pipeline.
    assign rd_pend_d  = m_en & ~m_we;
    assign rd_owner_d = w_d_gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_RUN;
            wait_q     <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign p_gnt      = w_p_gnt;
    assign d_gnt      = w_d_gnt;
    assign pipe_stall = p_req & ~w_p_gnt & rst;
    assign halt_ack   = (state_q == S_HALT);
    assign p_rvalid   = rd_pend_q & ~rd_owner_q;
    assign d_rvalid   = rd_pend_q & rd_owner_q;
    assign p_rdata    = p_rvalid ? m_rdata : '0;
    assign d_rdata    = d_rvalid ? m_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       p_req, p_we, d_req, d_we, halt_req;
    logic [7:0] p_addr, p_wdata, d_addr, d_wdata;
    logic       p_gnt, p_rvalid, d_gnt, d_rvalid, halt_ack, pipe_stall;
    logic [7:0] p_rdata, d_rdata;
    logic       m_en, m_we;
    logic [7:0] m_addr, m_wdata, m_rdata;
    logic [7:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(8), .DW(8), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .halt_req(halt_req), .halt_ack(halt_ack), .pipe_stall(pipe_stall),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    // Synchronous single-port RAM: read data appears the cycle after m_en & ~m_we.
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata <= mem[m_addr];
        end
    end

    task automatic idle_inputs();
        p_req = 0; p_we = 0; p_addr = 0; p_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        halt_req = 0;
    endtask

    // Advance to the next cycle: inputs are driven 1ns after the edge, checks 2ns later.
    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        idle_inputs();
        rst = 0;
        next_cycle(); settle();
        obs = {p_gnt, d_gnt, p_rvalid, d_rvalid, halt_ack, pipe_stall, m_en, m_we,
               |p_rdata, |d_rdata, |m_addr, |m_wdata, 2'b00};
        checks++;
        if (obs !== 14'd0) begin
            errors++; $display("FAIL reset_outputs: got %b expected all zero", obs);
        end
        rst = 1;
        next_cycle();
        p_req = 1; p_we = 0; p_addr = 8'h10;
        settle();
        checks++;
        if (p_gnt !== 1'b1) begin
            errors++; $display("FAIL reset_midread_gnt: got %b expected 1", p_gnt);
        end
        rst = 0;
        next_cycle(); idle_inputs(); settle();
        checks++;
        if (p_rvalid !== 1'b0) begin
            errors++; $display("FAIL reset_midread_rvalid: got %b expected 0", p_rvalid);
        end
        rst = 1;
        next_cycle(); settle();
        checks++;
        if (p_rvalid !== 1'b0) begin
            errors++; $display("FAIL reset_after_release_rvalid: got %b expected 0", p_rvalid);
        end
    endtask

    task automatic test_pipeline();
        next_cycle();
        p_req = 1; p_we = 1; p_addr = 8'h10; p_wdata = 8'h5A;
        settle();
        checks++;
        if ({p_gnt, pipe_stall, m_en, m_we, m_addr, m_wdata} !== {4'b1011, 8'h10, 8'h5A}) begin
            errors++;
            $display("FAIL pipe_write: got gnt=%b stall=%b en=%b we=%b a=%h d=%h expected 1 0 1 1 10 5a",
                     p_gnt, pipe_stall, m_en, m_we, m_addr, m_wdata);
        end
        next_cycle();
        p_we = 0; p_wdata = 0;
        settle();
        checks++;
        if ({p_gnt, pipe_stall, p_rvalid} !== 3'b100) begin
            errors++; $display("FAIL pipe_read_gnt: got gnt=%b stall=%b rvalid=%b expected 1 0 0",
                               p_gnt, pipe_stall, p_rvalid);
        end
        next_cycle();
        idle_inputs();
        settle();
        checks++;
        if ({p_rvalid, d_rvalid, p_rdata} !== {2'b10, 8'h5A}) begin
            errors++; $display("FAIL pipe_read_data: got prv=%b drv=%b data=%h expected 1 0 5a",
                               p_rvalid, d_rvalid, p_rdata);
        end
    endtask

    task automatic test_contention();
        logic [9:0] exp_p;
        exp_p = 10'b0111101111;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            p_req = 1; p_we = 1; p_addr = 8'h80; p_wdata = 8'hAA;
            d_req = 1; d_we = 1; d_addr = 8'h81; d_wdata = 8'hBB;
            settle();
            checks++;
            if ({p_gnt, d_gnt, pipe_stall} !== {exp_p[i], ~exp_p[i], ~exp_p[i]}) begin
                errors++;
                $display("FAIL contention_c%0d: got p=%b d=%b stall=%b expected %b %b %b",
                         i, p_gnt, d_gnt, pipe_stall, exp_p[i], ~exp_p[i], ~exp_p[i]);
            end
        end
        next_cycle(); idle_inputs();
    endtask

    task automatic test_alternating();
        next_cycle();
        p_req = 1; p_we = 1; p_addr = 8'h01; p_wdata = 8'h11;
        next_cycle();
        p_addr = 8'h02; p_wdata = 8'h22;
        next_cycle();
        p_we = 0; p_addr = 8'h01; p_wdata = 0;
        next_cycle();
        idle_inputs();
        d_req = 1; d_we = 0; d_addr = 8'h02;
        settle();
        checks++;
        if ({d_gnt, p_rvalid, d_rvalid, p_rdata, d_rdata} !== {3'b110, 8'h11, 8'h00}) begin
            errors++; $display("FAIL alt_pipe_resp: got dg=%b prv=%b drv=%b pd=%h dd=%h expected 1 1 0 11 00",
                               d_gnt, p_rvalid, d_rvalid, p_rdata, d_rdata);
        end
        next_cycle();
        idle_inputs();
        settle();
        checks++;
        if ({p_rvalid, d_rvalid, p_rdata, d_rdata} !== {2'b01, 8'h00, 8'h22}) begin
            errors++; $display("FAIL alt_debug_resp: got prv=%b drv=%b pd=%h dd=%h expected 0 1 00 22",
                               p_rvalid, d_rvalid, p_rdata, d_rdata);
        end
    endtask

    task automatic test_halt();
        next_cycle();
        halt_req = 1; p_req = 1; p_we = 0; p_addr = 8'h10;
        settle();
        checks++;
        if ({p_gnt, halt_ack} !== 2'b10) begin
            errors++; $display("FAIL halt_c0: got gnt=%b ack=%b expected 1 0", p_gnt, halt_ack);
        end
        next_cycle(); settle();
        checks++;
        if ({p_gnt, pipe_stall, halt_ack, p_rvalid, p_rdata} !== {4'b0101, 8'h5A}) begin
            errors++; $display("FAIL halt_drain: got gnt=%b stall=%b ack=%b rv=%b d=%h expected 0 1 0 1 5a",
                               p_gnt, pipe_stall, halt_ack, p_rvalid, p_rdata);
        end
        next_cycle(); settle();
        checks++;
        if ({p_gnt, halt_ack} !== 2'b01) begin
            errors++; $display("FAIL halt_c2_ack: got gnt=%b ack=%b expected 0 1", p_gnt, halt_ack);
        end
        next_cycle();
        d_req = 1; d_we = 1; d_addr = 8'h40; d_wdata = 8'h33;
        settle();
        checks++;
        if ({d_gnt, p_gnt, pipe_stall, m_we, m_addr, m_wdata} !== {4'b1011, 8'h40, 8'h33}) begin
            errors++; $display("FAIL halt_debug_write: got dg=%b pg=%b stall=%b we=%b a=%h d=%h expected 1 0 1 1 40 33",
                               d_gnt, p_gnt, pipe_stall, m_we, m_addr, m_wdata);
        end
        next_cycle();
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        next_cycle();
        halt_req = 0;
        settle();
        checks++;
        if ({halt_ack, p_gnt} !== 2'b10) begin
            errors++; $display("FAIL halt_c5: got ack=%b gnt=%b expected 1 0", halt_ack, p_gnt);
        end
        next_cycle(); settle();
        checks++;
        if ({halt_ack, p_gnt} !== 2'b01) begin
            errors++; $display("FAIL halt_resume: got ack=%b gnt=%b expected 0 1", halt_ack, p_gnt);
        end
        next_cycle();
        idle_inputs();
        d_req = 1; d_addr = 8'h40;
        next_cycle();
        idle_inputs();
        settle();
        checks++;
        if ({d_rvalid, d_rdata} !== {1'b1, 8'h33}) begin
            errors++; $display("FAIL halt_readback: got rv=%b d=%h expected 1 33", d_rvalid, d_rdata);
        end
    endtask

    task automatic test_halt_pulse();
        logic [4:0] exp_ack;
        exp_ack = 5'b00100;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            halt_req = (i == 0);
            settle();
            checks++;
            if (halt_ack !== exp_ack[i]) begin
                errors++; $display("FAIL halt_pulse_c%0d: got ack=%b expected %b", i, halt_ack, exp_ack[i]);
            end
        end
        next_cycle();
        p_req = 1; p_we = 1; p_addr = 8'h90;
        settle();
        checks++;
        if (p_gnt !== 1'b1) begin
            errors++; $display("FAIL halt_pulse_run: got gnt=%b expected 1", p_gnt);
        end
        next_cycle(); idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        m_rdata = 8'h00;
        idle_inputs();
        rst = 0;
        test_reset();
        test_pipeline();
        test_contention();
        test_alternating();
        test_halt();
        test_halt_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port 8-bit data RAM between the pipeline MEM stage and a debug/loader port. It grants at most one access per cycle and returns read data one cycle later to the requester that issued the read. It bounds debug starvation with a wait counter and provides a halt handshake that freezes pipeline memory traffic. It sits between the EX/MEM pipeline register and the data RAM and drives the pipeline stall request.

## Interface
- AW, 8, address width
- DW, 8, data width
- MAX_WAIT, 4, number of consecutive cycles a pending debug request may be denied before it is forced (≥1)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- p_req  in  1  pipeline access request; held until granted
- p_we  in  1  pipeline write (1) / read (0)
- p_addr  in  AW  pipeline address
- p_wdata  in  DW  pipeline write data
- p_gnt  out  1  pipeline access performed this cycle
- p_rvalid  out  1  pipeline read data valid
- p_rdata  out  DW  pipeline read data
- d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  debug port, same rules as pipeline
- d_gnt, d_rvalid  out  1  debug grant / read valid
- d_rdata  out  DW  debug read data
- halt_req  in  1  debug request to freeze pipeline memory access
- halt_ack  out  1  pipeline frozen; debug owns RAM exclusively
- pipe_stall  out  1  p_req & ~p_gnt
- m_en, m_we  out  1  RAM enable / write enable
- m_addr  out  AW  RAM address
- m_wdata  out  DW  RAM write data
- m_rdata  in  DW  RAM read data, valid the cycle after m_en & ~m_we

## Operation
- State machine: RUN, DRAIN, HALT. Reset → RUN.
- RUN: arbitration is combinational on the current requests.
  - Only p_req set: grant pipeline.
  - Only d_req set: grant debug.
  - Both set: grant pipeline unless wait_cnt == MAX_WAIT, in which case grant debug.
  - halt_req=1: next state DRAIN. Arbitration continues normally in the current cycle.
- DRAIN: pipeline is never granted. Debug is granted if d_req is set. Any read response from the previous cycle completes. Next state is HALT unconditionally.
- HALT: halt_ack=1. Pipeline is never granted. Debug is granted whenever d_req is set. When halt_req=0, next state is RUN and halt_ack drops in that cycle.
- wait_cnt (width ≥ clog2(MAX_WAIT+1)):
  - Increments when d_req=1 & d_gnt=0 and saturates at MAX_WAIT.
  - Clears to 0 when d_gnt=1 or d_req=0.
- Exactly one of p_gnt and d_gnt may be high in a cycle.
- m_en = p_gnt|d_gnt. m_we, m_addr and m_wdata are muxed from the granted requester. When no grant: m_addr=0, m_wdata=0, m_we=0.
- Read tracking: registers rd_owner and rd_pend capture the owner of a granted read.
  - Next cycle: the owner's rvalid=1 and its rdata=m_rdata.
  - The non-owner's rdata is held at 0.
- Writes produce no rvalid.

## Timing
- Grant latency is 0 cycles: grant is asserted in the same cycle as the request if arbitration selects it.
- Read latency is 1 cycle from grant to rvalid. Back-to-back reads from alternating requesters are supported at one per cycle, and each response is steered to its issuer.
- Starvation bound: a held d_req is granted no later than MAX_WAIT+1 cycles after assertion.
- Halt: halt_ack rises 2 cycles after halt_req rises (RUN→DRAIN→HALT). It falls 1 cycle after halt_req falls.
- Reset (asynchronous, any cycle):
  - All grants, rvalids, halt_ack, m_en and m_we are 0. Data outputs are 0.
  - wait_cnt=0, state=RUN, rd_pend=0.
  - A read outstanding at reset assertion is dropped with no rvalid.
- If halt_req is withdrawn while in DRAIN, the FSM still enters HALT for one cycle (halt_ack pulses), then returns to RUN.
- Simultaneous halt_req rise and pipeline read grant: the read completes, and p_rvalid appears during DRAIN.

## Test plan
- Reset then idle: all outputs 0. With rst low mid-read (p read granted at cycle n, rst asserted before cycle n+1), p_rvalid never rises.
- Pipeline only: write addr 0x10 data 0x5A, then read 0x10 → p_gnt both cycles, p_rvalid=1 with p_rdata=0x5A one cycle after the read grant, pipe_stall=0.
- Contention with MAX_WAIT=4: p_req and d_req held continuously → pipeline granted cycles 0–3, debug granted cycle 4, pipe_stall=1 in cycle 4, wait_cnt back to 0 in cycle 5.
- Alternating reads: pipeline reads 0x01 (=0x11) in cycle 0, debug reads 0x02 (=0x22) in cycle 1 → p_rvalid/0x11 in cycle 1, d_rvalid/0x22 in cycle 2, no cross-delivery.
- Halt: halt_req rises at cycle 0 with p_req held → halt_ack=1 at cycle 2. Debug writes 0x33 to 0x40 in cycle 3 with p_gnt=0 and pipe_stall=1. halt_req falls at cycle 5 → p_gnt=1 in cycle 6.
- Halt pulse: halt_req high for one cycle only → exactly one cycle of halt_ack, then RUN.
